s2_cfg_loader: RTL

Configuration controller for a bank of `N_CELLS` S2 logic cells. It accepts per-cell data-input nibbles (D00, D01, D10, D11) over a valid/ready stream and stages them in a shadow register. After an optional checksum check, it commits the nibbles atomically to the cells' D inputs. While a load is in progress, and until a valid configuration exists, it holds the cell registers cleared. It sits between the host configuration port and the S2 array.

---
 rtl/s2_cfg_loader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/s2_cfg_loader.sv
// ---------------------------------------------------------------------------
// s2_cfg_loader
//
// Configuration controller for a bank of N_CELLS S2 logic cells. Per-cell
// D-input nibbles (bit0=D00, bit1=D01, bit2=D10, bit3=D11) arrive over a
// valid/ready stream, cell 0 first, and are staged in a shadow register.
// Once the last nibble (and, optionally, a checksum nibble) is accepted, the
// shadow is committed atomically to cell_d. The cells are held in clear while
// a load is in progress and until a valid configuration has been committed.
//
// Optional feature macro: S2CFG_CHECKSUM_EN
//   defined   : one extra XOR-checksum nibble per load; mismatch sets cfg_err
//               and blocks the commit.
//   undefined : commit after the N_CELLS-th nibble; cfg_err stays 0.
//
// Ports
//   clk        in   sole clock, all state changes on posedge
//   clr        in   synchronous active-high reset, highest priority
//   start      in   begin a load (honoured only in IDLE)
//   abort      in   abandon current load, no commit, no error
//   cfg_valid  in   nibble present on cfg_data
//   cfg_data   in   [3:0] nibble for the current cell
//   cfg_ready  out  loader accepts a nibble this cycle
//   cell_d     out  [4*N_CELLS-1:0] active configuration, cell k at [4k+3:4k]
//   cell_clr   out  clear for every S2 cell
//   cfg_busy   out  any state other than IDLE
//   cfg_done   out  one-cycle pulse on commit
//   cfg_err    out  sticky checksum mismatch
// All outputs are registered.
// ---------------------------------------------------------------------------
module s2_cfg_loader #(
  parameter int N_CELLS = 4,
  parameter int IDX_W   = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 cfg_valid,
  input  logic [3:0]           cfg_data,
  output logic                 cfg_ready,
  output logic [4*N_CELLS-1:0] cell_d,
  output logic                 cell_clr,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CSUM   = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  // Running XOR checksum over accepted nibbles.
  function automatic logic [3:0] csum_fold(input logic [3:0] acc, input logic [3:0] nib);
    return acc ^ nib;
  endfunction

  state_t               state_r, state_nxt;
  logic [IDX_W-1:0]     idx_r, idx_nxt;
  logic [3:0]           csum_r, csum_nxt;
  logic [4*N_CELLS-1:0] shadow_r, shadow_nxt;
  logic                 cfg_ok_r;
  logic                 commit;
  logic                 err_set;
  logic                 err_clr;
  logic                 hs;

  // cfg_ready is registered and high exactly in LOAD/CSUM, so this is the handshake.
  assign hs = cfg_valid && cfg_ready;

  // Next-state, shadow/checksum update and commit/error decisions.
  always_comb begin
    state_nxt  = state_r;
    idx_nxt    = idx_r;
    csum_nxt   = csum_r;
    shadow_nxt = shadow_r;
    commit     = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
          csum_nxt  = 4'h0;
          err_clr   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // abort beats a simultaneous handshake: the nibble is dropped
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (hs) begin
          for (int k = 0; k < N_CELLS; k++) begin
            if (idx_r == IDX_W'(k)) begin
              shadow_nxt[4*k +: 4] = cfg_data;
            end else begin
              shadow_nxt[4*k +: 4] = shadow_r[4*k +: 4];
            end
          end
          csum_nxt = csum_fold(csum_r, cfg_data);
          if (idx_r == LAST_IDX) begin
`ifdef S2CFG_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_SETTLE;
            commit    = 1'b1;
`endif
          end else begin
            idx_nxt = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt = ST_LOAD;
        end
      end
`ifdef S2CFG_CHECKSUM_EN
      ST_CSUM: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (hs) begin
          if (csum_fold(csum_r, cfg_data) == 4'h0) begin
            state_nxt = ST_SETTLE;
            commit    = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            err_set   = 1'b1;
          end
        end else begin
          state_nxt = ST_CSUM;
        end
      end
`endif
      ST_SETTLE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, staging registers and registered outputs (derived from next state).
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      csum_r    <= 4'h0;
      shadow_r  <= '0;
      cfg_ok_r  <= 1'b0;
      cell_d    <= '0;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      cell_clr  <= 1'b1;
    end else begin
      state_r   <= state_nxt;
      idx_r     <= idx_nxt;
      csum_r    <= csum_nxt;
      shadow_r  <= shadow_nxt;
      cfg_ready <= (state_nxt == ST_LOAD) || (state_nxt == ST_CSUM);
      cfg_busy  <= (state_nxt != ST_IDLE);
      cfg_done  <= commit;
      // shadow_nxt already holds the final nibble when commit follows the last data nibble
      if (commit) begin
        cell_d   <= shadow_nxt;
        cfg_ok_r <= 1'b1;
      end else begin
        cell_d   <= cell_d;
        cfg_ok_r <= cfg_ok_r;
      end
      cell_clr <= (state_nxt != ST_IDLE) || !(cfg_ok_r || commit);
      if (err_clr) begin
        cfg_err <= 1'b0;
      end else if (err_set) begin
        cfg_err <= 1'b1;
      end else begin
        cfg_err <= cfg_err;
      end
    end
  end

endmodule
